// File: rtl/shared_bus_arbiter.sv
// Four-requester shared-bus arbiter: round-robin ownership with bounded bursts,
// a one-cycle turnaround between owners, and a keeper that holds the last bus value.
module shared_bus_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]    gnt,
  output logic [1:0]    owner,
  output logic          bus_valid,
  output logic [DW-1:0] bus_out
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  state_t               r_state, w_nxt_state;
  logic [1:0]           r_owner, w_nxt_owner, w_rr_pick, w_idx;
  logic                 w_rr_hit;
  logic [3:0]           r_cnt, w_nxt_cnt, r_gnt, w_nxt_gnt;
  logic [DW-1:0]        r_keep;
  logic [3:0][DW-1:0]   w_lane;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = wdata[DW*gi +: DW];
    end
  endgenerate

  // Search owner+1 .. owner+4 (the last being owner itself); scanning down lets
  // the nearest set bit overwrite, so the previous owner only wins when alone.
  always_comb begin
    w_rr_pick = r_owner;
    w_rr_hit  = 1'b0;
    w_idx     = r_owner;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_owner + 2'(k);
      if (req[w_idx]) begin
        w_rr_pick = w_idx;
        w_rr_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      IDLE, TURN: begin
        if (w_rr_hit) begin
          w_nxt_state = OWN;
          w_nxt_owner = w_rr_pick;
          w_nxt_cnt   = 4'd1;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      OWN: begin
        if (!req[r_owner] || (r_cnt == LP_MAX)) w_nxt_state = TURN;
        else                                   w_nxt_cnt   = r_cnt + 4'd1;
      end
      default: w_nxt_state = IDLE;
    endcase
    w_nxt_gnt = (w_nxt_state == OWN) ? (4'b0001 << w_nxt_owner) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= 2'd3;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'b0000;
      r_keep  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_cnt   <= w_nxt_cnt;
      r_gnt   <= w_nxt_gnt;
      if (r_state == OWN) r_keep <= w_lane[r_owner];
    end
  end

  assign gnt       = r_gnt;
  assign owner     = r_owner;
  assign bus_valid = (r_state == OWN);
  assign bus_out   = bus_valid ? w_lane[r_owner] : r_keep;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: vector table, directed corner sequences and
// randomized traffic against an ownership-level reference model.
module tb_shared_bus_arbiter;
  localparam int DW = 8;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [3:0]      req = '0, req1 = '0;
  logic [4*DW-1:0] wdata = '0;
  logic [3:0]      gnt, gnt1;
  logic [1:0]      owner, owner1;
  logic            bus_valid, bus_valid1;
  logic [DW-1:0]   bus_out, bus_out1;

  int checks = 0;
  int failures = 0;

  shared_bus_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .owner(owner), .bus_valid(bus_valid), .bus_out(bus_out));

  shared_bus_arbiter #(.DW(DW), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .wdata(wdata),
    .gnt(gnt1), .owner(owner1), .bus_valid(bus_valid1), .bus_out(bus_out1));

  always #5 clk = ~clk;

  // Reference: the bus is either owned (by m_owner, m_burst cycles so far) or
  // free. A free cycle hands the bus to the nearest requester after the last owner.
  bit            m_own;
  int            m_owner, m_burst;
  logic [DW-1:0] m_keep;
  logic [3:0]    prev_gnt;

  typedef struct {
    logic [3:0]    req;
    logic [3:0]    gnt;
    logic          vld;
    logic [1:0]    own;
    logic [DW-1:0] bus;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int i);
    return wdata[DW*i +: DW];
  endfunction

  task automatic model_reset();
    m_own = 0; m_owner = 3; m_burst = 0; m_keep = '0; prev_gnt = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (m_own) begin
      m_keep = lane(m_owner);
      if (!req[m_owner] || m_burst == MB) m_own = 0;
      else m_burst++;
    end else if (req != 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (req[(m_owner + k) % 4]) begin
          m_owner = (m_owner + k) % 4;
          break;
        end
      end
      m_own = 1; m_burst = 1;
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = m_own ? 4'(1 << m_owner) : 4'b0000;
    chk("m_gnt", gnt, eg);
    chk("m_valid", bus_valid, m_own);
    chk("m_owner", owner, m_owner);
    chk("m_bus", bus_out, m_own ? lane(m_owner) : m_keep);
    chk("no_contention", (prev_gnt != 0 && gnt != 0 && prev_gnt != gnt), 0);
    prev_gnt = gnt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    req = '0; req1 = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_owner", owner, 3);
    chk("rst_bus", bus_out, 0);
    chk("rst_gnt1", gnt1, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    wdata = {8'h77, 8'h3C, 8'h5A, 8'hA5};
    tbl[0]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 8'h5A};
    tbl[1]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 8'h5A};
    tbl[2]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 8'h5A};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 2'd1, 8'h5A};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd1, 8'h5A};
    tbl[5]  = '{4'b1000, 4'b1000, 1'b1, 2'd3, 8'h77};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd3, 8'h77};
    tbl[7]  = '{4'b0101, 4'b0001, 1'b1, 2'd0, 8'hA5};
    tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 8'hA5};
    tbl[9]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 8'h3C};
    tbl[10] = '{4'b0110, 4'b0100, 1'b1, 2'd2, 8'h3C};
    tbl[11] = '{4'b0010, 4'b0000, 1'b0, 2'd2, 8'h3C};
    tbl[12] = '{4'b0110, 4'b0010, 1'b1, 2'd1, 8'h5A};

    #1;
    do_reset();
    foreach (tbl[i]) begin
      req = tbl[i].req;
      step();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_valid", i), bus_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
      chk($sformatf("tbl%0d_bus", i), bus_out, tbl[i].bus);
    end

    // Two requesters sharing: full bursts alternating with a 1-cycle turnaround.
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 19; c++) begin
      step();
      chk($sformatf("alt%0d_gnt", c), gnt,
          (c < 8 || c == 18) ? 4'b0001 : (c >= 9 && c < 17) ? 4'b0100 : 4'b0000);
      chk($sformatf("alt%0d_bus", c), bus_out, (c < 9 || c == 18) ? 8'hA5 : 8'h3C);
    end

    // Lone requester 3 is re-granted after each forced turnaround.
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 18; c++) begin
      step();
      chk($sformatf("solo%0d_gnt", c), gnt, (c % 9 < 8) ? 4'b1000 : 4'b0000);
    end

    // All four requesting: rotation 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 45; c++) begin
      step();
      chk($sformatf("rot%0d_gnt", c), gnt, (c % 9 < 8) ? 4'(1 << ((c / 9) % 4)) : 4'b0000);
    end

    // Asynchronous reset in the middle of requester 2's ownership.
    do_reset();
    req = 4'b0100;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_valid", bus_valid, 0);
    chk("arst_bus", bus_out, 0);
    chk("arst_owner", owner, 3);
    model_reset();
    #1 rst_n = 1'b1;
    step();
    chk("arst_regrant", gnt, 4'b0100);

    // Single-cycle bursts on the MAX_BURST=1 instance.
    do_reset();
    req1 = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      step();
      chk($sformatf("mb1_%0d_gnt", c), gnt1, (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0000);
      chk($sformatf("mb1_%0d_valid", c), bus_valid1, (c % 2 == 0));
    end

    // Randomized traffic with sticky requests and occasional async resets.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      wdata = 32'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rnd_arst_gnt", gnt, 0);
        chk("rnd_arst_bus", bus_out, 0);
        #1 rst_n = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shared_bus_arbiter.md
SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, data width of each requester lane and of the resolved bus.
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum consecutive grant cycles per ownership; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-requester bus request, bit i = requester i.
REQ-006 SHALL have port wdata  input  4*DW  flat requester data, lane i at bits [DW*i +: DW].
REQ-007 SHALL have port gnt  output  4  registered one-hot grant (all-zero when bus not owned).
REQ-008 SHALL have port owner  output  2  index of current or most recent owner.
REQ-009 SHALL have port bus_valid  output  1  high exactly when a requester owns the bus.
REQ-010 SHALL have port bus_out  output  DW  resolved shared-bus value (owner lane, else keeper value).

Function
REQ-011 SHALL implement FSM with states IDLE, OWN, TURN; gnt nonzero only in OWN; bus_valid = (state==OWN).
REQ-012 IDLE: if req!=0, SHALL select next owner round-robin and enter OWN next cycle; else stay IDLE.
REQ-013 Round-robin SHALL search from owner+1 upward, wrapping 3->0; the first set req bit wins.
REQ-014 OWN: burst counter SHALL start at 1 on entry and increment by 1 each OWN cycle.
REQ-015 OWN SHALL exit to TURN on the edge where req[owner]==0, or where counter==MAX_BURST, whichever occurs first.
REQ-016 TURN SHALL last exactly 1 cycle with gnt=0; it guarantees no two owners are granted on adjacent cycles (no contention).
REQ-017 TURN: if req!=0, SHALL select the next owner per REQ-013 and enter OWN; else enter IDLE.
REQ-018 The previous owner SHALL be re-grantable from TURN only if no other requester is asserting req (fair rotation).
REQ-019 In OWN, bus_out SHALL equal wdata lane [owner] combinationally (same-cycle data, no added latency).
REQ-020 Outside OWN, bus_out SHALL hold the last value driven during OWN (keeper/charge-storage behaviour); never X or Z.
REQ-021 Grant latency: req asserted in cycle n from IDLE -> gnt visible in cycle n+1.
REQ-022 Back-to-back ownership hand-off gap SHALL be exactly 1 cycle (TURN).
REQ-023 req changes on a non-owner during OWN SHALL not affect the current grant.
REQ-024 Burst counter SHALL be 4 bits; it SHALL never wrap because exit is forced at MAX_BURST.
REQ-025 With MAX_BURST=1, every ownership SHALL be exactly 1 cycle followed by TURN.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, gnt=0, bus_valid=0, owner=3 (so requester 0 has first priority), counter=0, keeper=0, bus_out=0.
REQ-027 Reset asserted mid-OWN SHALL drop gnt and bus_valid immediately, without waiting for a clock edge.
REQ-028 After rst_n deasserts, first grant SHALL follow REQ-012 with round-robin pointer at owner=3.

Verification
REQ-029 Reset, then req=4'b0101 held, lane0=8'hA5, lane2=8'h3C -> gnt 0001 for 8 cycles with bus_out=A5, TURN 1 cycle, gnt 0100 for 8 cycles with bus_out=3C, TURN, back to 0001.
REQ-030 req=4'b0010 for 3 cycles then 0, lane1=8'h5A -> gnt 0010 for 3 cycles, TURN, IDLE; bus_out stays 5A, bus_valid=0.
REQ-031 Requester 3 alone, req held high, MAX_BURST=8 -> OWN 8 cycles, TURN 1, re-granted 3; pattern repeats with 1-cycle gaps.
REQ-032 All four req high continuously -> grant order 0,1,2,3,0 each for MAX_BURST cycles; gnt never nonzero on two adjacent cycles with different owners.
REQ-033 rst_n pulsed low during OWN of requester 2 -> gnt=0, bus_valid=0, bus_out=0 before the next edge; after release with req=4'b0100, gnt=0100 one cycle later.
REQ-034 MAX_BURST=1 build, req=4'b1111 -> alternating OWN/TURN, owners 0,1,2,3 each for 1 cycle.
